// File: rtl/dsiq_tx_buffer.sv
// TX IQ byte assembler feeding a FWFT sample FIFO with prefill gating and sticky error flags.
// Bytes arrive I1,I0,Q1,Q0; each completed sample is stored as {cwx,ptt,I,Q}.
module dsiq_tx_buffer #(
  parameter int DEPTH_LOG2 = 10,
  parameter int PREFILL    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [7:0]            dseth_tdata,
  input  logic                  dsethiq_tvalid,
  input  logic                  dsethiq_tlast,
  input  logic                  dsethiq_tuser,
  output logic [31:0]           tx_tdata,
  output logic [1:0]            tx_tuser,
  output logic                  tx_tvalid,
  input  logic                  tx_tready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  frame_err,
  input  logic                  clr_flags
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  typedef enum logic {FILL, STREAM} state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  i_hi_q, i_hi_d, i_lo_q, i_lo_d, q_hi_q, q_hi_d;
  logic        ptt_q, ptt_d, cwx_q, cwx_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        out_vld_q, out_vld_d;
  logic [33:0] out_data_q, out_data_d;
  logic        overflow_q, overflow_d, underflow_q, underflow_d, frame_err_q, frame_err_d;

  logic [33:0] mem [DEPTH];
  logic [33:0] wr_word;
  logic [PW-1:0] count, rd_after;
  logic        full, pop, word_done, push;

  assign count     = wr_ptr_q - rd_ptr_q;
  // The memory slot under rd_ptr stays occupied until popped, so level
  // already counts the output register and capacity is exactly DEPTH.
  assign full      = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
  assign tx_tvalid = out_vld_q && (state_q == STREAM);
  assign pop       = tx_tvalid && tx_tready;
  assign word_done = dsethiq_tvalid && (byte_idx_q == 2'd3);
  assign push      = word_done && (!full || pop);
  assign rd_after  = rd_ptr_q + PW'(pop);
  assign wr_word   = {cwx_q, ptt_q, i_hi_q, i_lo_q, q_hi_q, dseth_tdata};

  assign tx_tdata  = out_data_q[31:0];
  assign tx_tuser  = out_data_q[33:32];
  assign level     = count;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign frame_err = frame_err_q;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    i_hi_d     = i_hi_q;
    i_lo_d     = i_lo_q;
    q_hi_d     = q_hi_q;
    ptt_d      = ptt_q;
    cwx_d      = cwx_q;
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_after;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;

    if (dsethiq_tvalid) begin
      byte_idx_d = dsethiq_tlast ? 2'd0 : byte_idx_q + 2'd1;
      case (byte_idx_q)
        2'd0:    begin i_hi_d = dseth_tdata; ptt_d = dsethiq_tuser; end
        2'd1:    begin i_lo_d = dseth_tdata; cwx_d = dsethiq_tuser; end
        2'd2:    q_hi_d = dseth_tdata;
        default: ;
      endcase
    end

    // Reload from the already-committed FIFO contents only, which gives the
    // one-cycle gap between level rising and the word presenting.
    if (pop || !out_vld_q) begin
      if (rd_after != wr_ptr_q) begin
        out_data_d = mem[rd_after[PW-2:0]];
        out_vld_d  = 1'b1;
      end else begin
        out_vld_d  = 1'b0;
      end
    end

    case (state_q)
      FILL:    if (count >= PW'(PREFILL)) state_d = STREAM;
      default: if (count == '0) state_d = FILL;
    endcase

    overflow_d  = (overflow_q  && !clr_flags) || (word_done && full && !pop);
    underflow_d = (underflow_q && !clr_flags) ||
                  (state_q == STREAM && count == '0 && tx_tready);
    frame_err_d = (frame_err_q && !clr_flags) ||
                  (dsethiq_tvalid && (dsethiq_tlast != (byte_idx_q == 2'd3)));

    if (flush) begin
      state_d    = FILL;
      byte_idx_d = 2'd0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      out_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FILL;
      byte_idx_q  <= 2'd0;
      i_hi_q      <= '0;
      i_lo_q      <= '0;
      q_hi_q      <= '0;
      ptt_q       <= 1'b0;
      cwx_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      i_hi_q      <= i_hi_d;
      i_lo_q      <= i_lo_d;
      q_hi_q      <= q_hi_d;
      ptt_q       <= ptt_d;
      cwx_q       <= cwx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push && !flush) mem[wr_ptr_q[PW-2:0]] <= wr_word;
  end

endmodule

// File: tb/tb_dsiq_tx_buffer.sv
// Scoreboard bench for dsiq_tx_buffer with an 8-word FIFO and PREFILL=4.
module tb_dsiq_tx_buffer;
  logic        clk = 1'b0;
  logic        rst_n, flush, clr_flags;
  logic [7:0]  dseth_tdata;
  logic        dsethiq_tvalid, dsethiq_tlast, dsethiq_tuser;
  logic [31:0] tx_tdata;
  logic [1:0]  tx_tuser;
  logic        tx_tvalid, tx_tready;
  logic [3:0]  level;
  logic        overflow, underflow, frame_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [33:0] exp_q[$];

  dsiq_tx_buffer #(.DEPTH_LOG2(3), .PREFILL(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .dseth_tdata(dseth_tdata), .dsethiq_tvalid(dsethiq_tvalid),
    .dsethiq_tlast(dsethiq_tlast), .dsethiq_tuser(dsethiq_tuser),
    .tx_tdata(tx_tdata), .tx_tuser(tx_tuser), .tx_tvalid(tx_tvalid),
    .tx_tready(tx_tready), .level(level), .overflow(overflow),
    .underflow(underflow), .frame_err(frame_err), .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Every accepted handshake is matched against the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && tx_tvalid && tx_tready) begin
      if (exp_q.size() == 0) chk("unexpected_pop", 64'(tx_tdata), 64'hdead);
      else chk("tx_word", 64'({tx_tuser, tx_tdata}), 64'(exp_q.pop_front()));
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input logic u);
    dseth_tdata = d; dsethiq_tvalid = 1'b1; dsethiq_tlast = last; dsethiq_tuser = u;
    tick();
    dsethiq_tvalid = 1'b0; dsethiq_tlast = 1'b0; dsethiq_tuser = 1'b0;
  endtask

  task automatic send_sample(input logic [15:0] i, input logic [15:0] q,
                             input logic [3:0] u, input logic last3, input logic exp);
    if (exp) exp_q.push_back({u[1], u[0], i, q});
    send_byte(i[15:8], 1'b0, u[0]);
    send_byte(i[7:0],  1'b0, u[1]);
    send_byte(q[15:8], 1'b0, u[2]);
    send_byte(q[7:0],  last3, u[3]);
  endtask

  task automatic pulse_clr;
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
  endtask

  task automatic wait_level(input string tag, input logic [3:0] tgt);
    bit hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk);
      if (level == tgt) hit = 1'b1;
    end
    chk(tag, 64'(level), 64'(tgt));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; clr_flags = 1'b0; tx_tready = 1'b0;
    dseth_tdata = '0; dsethiq_tvalid = 1'b0; dsethiq_tlast = 1'b0; dsethiq_tuser = 1'b0;
    repeat (3) tick();
    chk("rst_tvalid", 64'(tx_tvalid), 0);
    chk("rst_level", 64'(level), 0);
    chk("rst_flags", 64'({overflow, underflow, frame_err}), 0);
    chk("rst_data", 64'({tx_tuser, tx_tdata}), 0);
    rst_n = 1'b1;
    tick();

    // Prefill then stream four words back to back.
    tx_tready = 1'b1;
    for (int n = 0; n < 4; n++)
      send_sample(16'h1234 + 16'(n), 16'h8000 + 16'(n), 4'b0000, 1'b1, 1'b1);
    chk("t1_level_n1", 64'(level), 4);
    chk("t1_tvalid_n1", 64'(tx_tvalid), 0);
    tick();
    chk("t1_tvalid_n2", 64'(tx_tvalid), 1);
    wait_level("t1_drain", 4'd0);
    chk("t1_uf_before", 64'(underflow), 0);
    tick();
    chk("t1_underflow", 64'(underflow), 1);
    chk("t1_fill_tvalid", 64'(tx_tvalid), 0);
    tx_tready = 1'b0;
    pulse_clr();
    chk("t1_uf_clr", 64'(underflow), 0);

    // PTT/CWX capture; tuser on Q bytes must be ignored.
    send_sample(16'hA001, 16'hB001, 4'b0001, 1'b1, 1'b1);
    send_sample(16'hA002, 16'hB002, 4'b0010, 1'b1, 1'b1);
    send_sample(16'hA003, 16'hB003, 4'b0011, 1'b1, 1'b1);
    send_sample(16'hA004, 16'hB004, 4'b1100, 1'b1, 1'b1);
    chk("t2_level", 64'(level), 4);
    tx_tready = 1'b1;
    wait_level("t2_drain", 4'd0);
    tick(); tick();
    tx_tready = 1'b0;
    pulse_clr();

    // Framing errors.
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    chk("t3_ferr", 64'(frame_err), 1);
    chk("t3_level0", 64'(level), 0);
    send_sample(16'hC0DE, 16'hBEEF, 4'b0000, 1'b1, 1'b0);
    chk("t3_level1", 64'(level), 1);
    pulse_clr();
    chk("t3_ferr_clr", 64'(frame_err), 0);
    send_sample(16'h5555, 16'h6666, 4'b0000, 1'b0, 1'b0);
    chk("t3_nolast_level", 64'(level), 2);
    chk("t3_nolast_ferr", 64'(frame_err), 1);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t3_flush_level", 64'(level), 0);
    chk("t3_flush_keeps_flag", 64'(frame_err), 1);
    pulse_clr();

    // Overflow: 10 samples into 8 slots, only the first 8 survive.
    for (int n = 0; n < 10; n++)
      send_sample(16'h0100 + 16'(n), 16'h0200 + 16'(n), 4'b0000, 1'b1, n < 8);
    chk("t4_level", 64'(level), 8);
    chk("t4_overflow", 64'(overflow), 1);
    pulse_clr();
    chk("t4_ovf_clr", 64'(overflow), 0);

    // Push and pop together on a full FIFO.
    exp_q.push_back({2'b00, 16'h7777, 16'h8888});
    send_byte(8'h77, 1'b0, 1'b0);
    send_byte(8'h77, 1'b0, 1'b0);
    send_byte(8'h88, 1'b0, 1'b0);
    tx_tready = 1'b1;
    send_byte(8'h88, 1'b1, 1'b0);
    tx_tready = 1'b0;
    chk("t5_level", 64'(level), 8);
    chk("t5_overflow", 64'(overflow), 0);
    tx_tready = 1'b1;
    wait_level("t5_drain", 4'd0);
    chk("t5_sb_empty", 64'(exp_q.size()), 0);
    tick(); tick();
    tx_tready = 1'b0;
    pulse_clr();

    // Reset in the middle of a sample.
    send_sample(16'h4242, 16'h4343, 4'b0000, 1'b1, 1'b0);
    send_byte(8'h99, 1'b1, 1'b0);
    send_byte(8'hAA, 1'b0, 1'b1);
    send_byte(8'hBB, 1'b0, 1'b1);
    send_byte(8'hCC, 1'b0, 1'b0);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("t6_level", 64'(level), 0);
    chk("t6_flags", 64'({overflow, underflow, frame_err}), 0);
    chk("t6_data", 64'({tx_tuser, tx_tvalid, tx_tdata}), 0);
    tx_tready = 1'b1;
    send_sample(16'hD000, 16'hE000, 4'b0000, 1'b1, 1'b1);
    chk("t6_clean_level", 64'(level), 1);
    chk("t6_clean_ferr", 64'(frame_err), 0);
    for (int n = 1; n < 4; n++)
      send_sample(16'hD000 + 16'(n), 16'hE000 + 16'(n), 4'b0000, 1'b1, 1'b1);
    wait_level("t6_drain", 4'd0);
    tick(); tick();
    chk("final_sb_empty", 64'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
